// File: rtl/io_port_endpoint.sv
// rtl/io_port_endpoint.sv - Octavo I/O port endpoint: host-filled read FIFO, host-drained write FIFO (optional: IO_PORT_ENDPOINT_LOOPBACK_EN)

module io_port_fifo #(
    parameter int    WORD_WIDTH      = 36,
    parameter int    FIFO_DEPTH      = 4,
    parameter int    FIFO_ADDR_WIDTH = 2,
    parameter string RAMSTYLE        = "MLAB, no_rw_check"
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WORD_WIDTH-1:0]      push_data,
    input  logic                       pop,
    output logic [WORD_WIDTH-1:0]      head_data,
    output logic [FIFO_ADDR_WIDTH:0]   count,
    output logic                       not_empty,
    output logic                       not_full
);

    (* ramstyle = RAMSTYLE *) logic [WORD_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_ADDR_WIDTH:0]   count_q, count_d;

    // Next pointers and occupancy; push/pop arrive already qualified by the flags
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + (FIFO_ADDR_WIDTH+1)'(push) - (FIFO_ADDR_WIDTH+1)'(pop);
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Pointer/occupancy registers; reset empties the FIFO and discards any same-cycle strobe
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents are not reset since data is only meaningful while valid
    always_ff @(posedge clock) begin
        if (reset_n && push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign not_empty = (count_q != '0);
    assign not_full  = (count_q != (FIFO_ADDR_WIDTH+1)'(FIFO_DEPTH));

endmodule

module io_port_endpoint #(
    parameter int    WORD_WIDTH      = 36,
    parameter int    FIFO_DEPTH      = 4,
    parameter int    FIFO_ADDR_WIDTH = 2,
    parameter string RAMSTYLE        = "MLAB, no_rw_check"
) (
    input  logic                       clock,
    input  logic                       reset_n,
`ifdef IO_PORT_ENDPOINT_LOOPBACK_EN
    input  logic                       loopback,
`endif
    output logic                       io_read_EF,
    output logic [WORD_WIDTH-1:0]      io_read_data,
    input  logic                       io_rden,
    output logic                       io_write_EF,
    input  logic [WORD_WIDTH-1:0]      io_write_data,
    input  logic                       io_wren,
    input  logic [WORD_WIDTH-1:0]      host_in_data,
    input  logic                       host_in_valid,
    output logic                       host_in_ready,
    output logic [WORD_WIDTH-1:0]      host_out_data,
    output logic                       host_out_valid,
    input  logic                       host_out_ready,
    output logic [FIFO_ADDR_WIDTH:0]   rd_count,
    output logic [FIFO_ADDR_WIDTH:0]   wr_count,
    output logic                       underflow,
    output logic                       overflow,
    input  logic                       error_clear
);

    logic                  rd_not_empty, rd_not_full, wr_not_empty, wr_not_full;
    logic                  rd_push, rd_pop, wr_push, wr_pop;
    logic [WORD_WIDTH-1:0] rd_push_data, wr_head;
    logic                  lb;
    logic                  underflow_q, underflow_d;
    logic                  overflow_q, overflow_d;

`ifdef IO_PORT_ENDPOINT_LOOPBACK_EN
    assign lb = loopback;
`else
    assign lb = 1'b0;
`endif

    // Lane strobe qualification; in loopback the write head moves straight into the read FIFO
    always_comb begin
        rd_pop       = io_rden & rd_not_empty;
        wr_push      = io_wren & wr_not_full;
        rd_push      = host_in_valid & rd_not_full;
        rd_push_data = host_in_data;
        wr_pop       = host_out_ready & wr_not_empty;
        if (lb) begin
            rd_push      = wr_not_empty & rd_not_full;
            rd_push_data = wr_head;
            wr_pop       = wr_not_empty & rd_not_full;
        end
    end

    io_port_fifo #(
        .WORD_WIDTH(WORD_WIDTH), .FIFO_DEPTH(FIFO_DEPTH),
        .FIFO_ADDR_WIDTH(FIFO_ADDR_WIDTH), .RAMSTYLE(RAMSTYLE)
    ) u_read_fifo (
        .clock(clock), .reset_n(reset_n),
        .push(rd_push), .push_data(rd_push_data), .pop(rd_pop),
        .head_data(io_read_data), .count(rd_count),
        .not_empty(rd_not_empty), .not_full(rd_not_full)
    );

    io_port_fifo #(
        .WORD_WIDTH(WORD_WIDTH), .FIFO_DEPTH(FIFO_DEPTH),
        .FIFO_ADDR_WIDTH(FIFO_ADDR_WIDTH), .RAMSTYLE(RAMSTYLE)
    ) u_write_fifo (
        .clock(clock), .reset_n(reset_n),
        .push(wr_push), .push_data(io_write_data), .pop(wr_pop),
        .head_data(wr_head), .count(wr_count),
        .not_empty(wr_not_empty), .not_full(wr_not_full)
    );

    // Sticky error flags: a new error event outranks a simultaneous clear
    always_comb begin
        underflow_d = underflow_q;
        overflow_d  = overflow_q;
        if (error_clear) begin
            underflow_d = 1'b0;
            overflow_d  = 1'b0;
        end
        if (io_rden && !rd_not_empty) underflow_d = 1'b1;
        if (io_wren && !wr_not_full)  overflow_d  = 1'b1;
    end

    // Error flag registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            underflow_q <= underflow_d;
            overflow_q  <= overflow_d;
        end
    end

    assign io_read_EF     = rd_not_empty;
    assign io_write_EF    = wr_not_full;
    assign host_in_ready  = rd_not_full & ~lb;
    assign host_out_valid = wr_not_empty & ~lb;
    assign host_out_data  = wr_head;
    assign underflow      = underflow_q;
    assign overflow       = overflow_q;

endmodule

// File: doc/io_port_endpoint.md
Name: io_port_endpoint

Overview:
- External-side endpoint for one Octavo I/O port pair.
- Read lane: serves the CPU's `io_read_data_*` / `io_read_EF_*` / `io_rden_*` lane, backed by a FIFO that the host fills.
- Write lane: absorbs `io_write_data_*` / `io_wren_*` and reports space on `io_write_EF_*`, backed by a FIFO that the host drains.
- The bench and SoC glue instantiate IO_PORT_COUNT copies per side (A and B), one per port slice.

Parameters:
- WORD_WIDTH, 36, data word width; matches the CPU datapath.
- FIFO_DEPTH, 4, entries per FIFO; must be a power of two and at least 2.
- FIFO_ADDR_WIDTH, 2, log2(FIFO_DEPTH).
- RAMSTYLE, "MLAB, no_rw_check", storage synthesis attribute.

Ports:
- clock  in  1  single clock.
- reset_n  in  1  synchronous, active-low reset.
- io_read_EF  out  1  1 = read FIFO non-empty; CPU may read.
- io_read_data  out  WORD_WIDTH  head of read FIFO (first-word-fall-through).
- io_rden  in  1  CPU read strobe; pops read FIFO.
- io_write_EF  out  1  1 = write FIFO not full; CPU may write.
- io_write_data  in  WORD_WIDTH  CPU write data.
- io_wren  in  1  CPU write strobe; pushes write FIFO.
- host_in_data  in  WORD_WIDTH  host word destined for the CPU.
- host_in_valid  in  1  host push request.
- host_in_ready  out  1  read FIFO not full.
- host_out_data  out  WORD_WIDTH  head of write FIFO.
- host_out_valid  out  1  write FIFO non-empty.
- host_out_ready  in  1  host pop acknowledge.
- rd_count  out  FIFO_ADDR_WIDTH+1  read FIFO occupancy.
- wr_count  out  FIFO_ADDR_WIDTH+1  write FIFO occupancy.
- underflow  out  1  sticky: io_rden seen while io_read_EF=0.
- overflow  out  1  sticky: io_wren seen while io_write_EF=0.
- error_clear  in  1  synchronous clear of the sticky error flags.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - Both FIFOs empty; rd_count = wr_count = 0.
  - io_read_EF = 0, host_out_valid = 0.
  - io_write_EF = 1, host_in_ready = 1.
  - underflow = overflow = 0.
  - Data outputs are don't-care until valid.
  - Reset mid-transfer discards all contents; a push or pop in the same cycle as reset is ignored.
- Each FIFO:
  - Write pointer, read pointer and occupancy counter, all registered.
  - Pointers wrap modulo FIFO_DEPTH.
  - Count ranges 0..FIFO_DEPTH.
- Flags:
  - Derived from registered occupancy only (no combinational path from strobes).
  - EF/valid = (count != 0).
  - EF/ready = (count != FIFO_DEPTH).
- Read lane:
  - Push = host_in_valid & host_in_ready.
  - Pop = io_rden & io_read_EF.
- Write lane:
  - Push = io_wren & io_write_EF.
  - Pop = host_out_valid & host_out_ready.
- Latency:
  - A pushed word is visible at the head the cycle after the push edge; flags update on that same edge. Empty-to-visible latency is 1 cycle.
  - The head data changes on the edge of a pop.
- Simultaneous push and pop:
  - Both occur; count unchanged.
  - When full, push is already blocked by ready=0, so only the pop occurs; the slot frees next cycle. No bypass.
  - When empty, pop is blocked by EF=0, so only the push occurs.
- Illegal strobes:
  - io_rden while io_read_EF=0: no pop, underflow <= 1.
  - io_wren while io_write_EF=0: word dropped, overflow <= 1.
- Sticky errors:
  - error_clear=1 clears both flags.
  - An error event in the same cycle as error_clear wins, leaving the flag set.
- Data ordering: strict FIFO order per lane; the lanes are independent.

Optional Feature:
- Macro: IO_PORT_ENDPOINT_LOOPBACK_EN.
- When defined:
  - Extra input port `loopback` (1 bit).
  - While loopback=1, the write FIFO head feeds the read FIFO push (push when write non-empty and read not full; one word per cycle).
  - host_out_valid and host_in_ready are forced to 0.
  - Host strobes are ignored.
- When undefined: no `loopback` port; behaviour exactly as above.

Test Plan:
- Reset/flags: hold reset_n=0 for 3 cycles, then release -> io_read_EF=0, io_write_EF=1, host_in_ready=1, host_out_valid=0, both counts 0, both errors 0.
- Read fill/drain: host pushes 0x000000001..0x000000004 on consecutive cycles -> host_in_ready=0 after the 4th, rd_count=4. io_rden on 4 cycles -> data 1,2,3,4 in order, then io_read_EF=0.
- Write full and overflow: with host_out_ready=0, io_wren for 5 cycles with 0xA..0xE -> io_write_EF=0 after 4, the 5th word (0xE) dropped, overflow=1. Drain -> 0xA..0xD only.
- Underflow and clear: io_rden while empty -> underflow=1, rd_count stays 0. Assert error_clear together with another empty io_rden -> underflow stays 1. error_clear alone -> 0.
- Simultaneous push/pop at count=2 on both lanes for 10 cycles with an incrementing pattern -> counts stay 2, output sequence matches input order with 2-word lag.
- Reset mid-operation: read FIFO at count=3, assert reset_n=0 together with host push and io_rden -> next cycle rd_count=0, io_read_EF=0, no data emitted. With IO_PORT_ENDPOINT_LOOPBACK_EN and loopback=1: CPU writes 0x123456789 -> appears at io_read_data 2 cycles later, host_out_valid stays 0.
